// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the run controller and its surroundings
// (divider tick, board switch/button, core halt/PC, and the enable/status outputs).
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic              tick_in;
    logic              sw_run;
    logic              btn_step;
    logic              halt;
    logic [31:0]       pc;
    logic [31:0]       bp_addr;
    logic              cpu_en;
    logic              running;
    logic              halted;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output tick_in, sw_run, btn_step, halt, pc, bp_addr,
        input  cpu_en, running, halted, cycle_count
    );

    modport slave (
        input  tick_in, sw_run, btn_step, halt, pc, bp_addr,
        output cpu_en, running, halted, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/pause/single-step controller turning divider ticks into a one-clk core enable.
// Optional PC breakpoint pause is compiled in with RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int unsigned DEB_CYCLES = 20,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    cpu_run_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

    logic             tick_s1_q, tick_s2_q, tick_dly_q;
    logic             run_s1_q, run_s2_q;
    logic             btn_s1_q, btn_s2_q;
    logic [19:0]      deb_cnt_q, deb_cnt_d;
    logic             deb_lvl_q, deb_lvl_d;
    logic             step_req_q, step_req_d;
    state_e           state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             running_q, halted_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic             tick_s;
    logic             run_ok_s;

    assign tick_s = tick_s2_q & ~tick_dly_q;

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic bp_hold_q, bp_hold_d;
    logic bp_hit_s;
    assign bp_hit_s = (bus.pc == bus.bp_addr);
    // A breakpoint pause blocks re-entry to RUN until the switch has been seen low.
    assign run_ok_s = run_s2_q & ~bp_hold_q;

    // Breakpoint hold flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_hold_q <= 1'b0;
        end else begin
            bp_hold_q <= bp_hold_d;
        end
    end
`else
    logic unused_bp_s;
    assign unused_bp_s = ^{bus.pc, bus.bp_addr};
    assign run_ok_s    = run_s2_q;
`endif

    // Input synchronizers and tick edge-detect delay flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_s1_q  <= 1'b0;
            tick_s2_q  <= 1'b0;
            tick_dly_q <= 1'b0;
            run_s1_q   <= 1'b0;
            run_s2_q   <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
        end else begin
            tick_s1_q  <= bus.tick_in;
            tick_s2_q  <= tick_s1_q;
            tick_dly_q <= tick_s2_q;
            run_s1_q   <= bus.sw_run;
            run_s2_q   <= run_s1_q;
            btn_s1_q   <= bus.btn_step;
            btn_s2_q   <= btn_s1_q;
        end
    end

    // Step-button debounce: level flips after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_cnt_d  = 20'd0;
        deb_lvl_d  = deb_lvl_q;
        step_req_d = 1'b0;
        if (btn_s2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_d  = ~deb_lvl_q;
                step_req_d = ~deb_lvl_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 20'd1;
            end
        end else begin
            deb_cnt_d = 20'd0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_q  <= 20'd0;
            deb_lvl_q  <= 1'b0;
            step_req_q <= 1'b0;
        end else begin
            deb_cnt_q  <= deb_cnt_d;
            deb_lvl_q  <= deb_lvl_d;
            step_req_q <= step_req_d;
        end
    end

    // Run-control next state and enable decision; halt outranks everything but reset.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
        bp_hold_d = bp_hold_q & run_s2_q;
`endif
        case (state_q)
            ST_PAUSE: begin
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (run_ok_s) begin
                    state_d = ST_RUN;
                end else if (step_req_q) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else begin
                    cpu_en_d = tick_s;
                    if (!run_s2_q) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                    end
`ifdef RUN_CTRL_BREAKPOINT_EN
                    if (tick_s && bp_hit_s) begin
                        state_d   = ST_PAUSE;
                        bp_hold_d = 1'b1;
                    end else begin
                        bp_hold_d = bp_hold_d;
                    end
`endif
                end
            end
            ST_STEP: begin
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (tick_s) begin
                    cpu_en_d = 1'b1;
                    state_d  = ST_PAUSE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_PAUSE;
            end
        endcase
    end

    // State, registered status outputs and pulse counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_PAUSE;
            cpu_en_q      <= 1'b0;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cpu_en_q      <= cpu_en_d;
            running_q     <= (state_d == ST_RUN);
            halted_q      <= (state_d == ST_HALT);
            cycle_count_q <= cycle_count_q + {{(CNT_W-1){1'b0}}, cpu_en_q};
        end
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.cycle_count = cycle_count_q;
endmodule
